// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave with NUM_REGS 32-bit read/write registers, byte strobes and independent AW/W capture.
// Optional AXIL_REG_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_reg_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS           = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned IW = C_S_AXI_ADDR_WIDTH - 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  logic [DW-1:0] regs [NUM_REGS];

  logic          aw_held;
  logic          w_held;
  logic [IW-1:0] aw_idx;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;

  logic          aw_hs_c;
  logic          w_hs_c;
  logic          ar_hs_c;
  logic          commit_c;
  logic [IW-1:0] ar_idx_c;
  logic          aw_in_range_c;
  logic          ar_in_range_c;
  logic [DW-1:0] rd_word_c;
  logic          unused_ok;

  // Protection bits and byte offset carry no meaning for word registers
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = ~aw_held;
  assign S_AXI_WREADY  = ~w_held;
  assign S_AXI_ARREADY = ~S_AXI_RVALID;

  assign aw_hs_c       = S_AXI_AWVALID & ~aw_held;
  assign w_hs_c        = S_AXI_WVALID & ~w_held;
  assign ar_hs_c       = S_AXI_ARVALID & ~S_AXI_RVALID;
  assign commit_c      = aw_held & w_held & ~S_AXI_BVALID;
  assign ar_idx_c      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_in_range_c = 32'(aw_idx) < NUM_REGS;
  assign ar_in_range_c = 32'(ar_idx_c) < NUM_REGS;

  // Read mux; unimplemented indices read as zero
  always_comb begin
    rd_word_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ar_idx_c == IW'(i)) rd_word_c = regs[i];
    end
  end

  // Write channel: independent AW/W holds, commit once both present and no response outstanding
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (aw_hs_c) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end else if (commit_c) begin
        aw_held <= 1'b0;
      end

      if (w_hs_c) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end else if (commit_c) begin
        w_held <= 1'b0;
      end

      if (commit_c) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= aw_in_range_c ? RESP_OKAY : RESP_OOR;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end

      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (commit_c && aw_idx == IW'(i)) begin
          for (int unsigned b = 0; b < SW; b++) begin
            if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read channel: data captured at the AR handshake, so a same-edge commit is not yet visible
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else if (ar_hs_c) begin
      S_AXI_RVALID <= 1'b1;
      S_AXI_RDATA  <= rd_word_c;
      S_AXI_RRESP  <= ar_in_range_c ? RESP_OKAY : RESP_OOR;
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed self-checking bench for axil_reg_slave; honours AXIL_REG_SLVERR_EN for out-of-range responses.
module tb_axil_reg_slave;

`ifdef AXIL_REG_SLVERR_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        aresetn;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_regs [4];

  always #5 clk = ~clk;

  axil_reg_slave dut (
    .ACLK(clk), .ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_hs, w_hs;
    int n = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick(); n++;
      if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1; wvalid  = 1'b0; end
    end
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk("wr_bvalid", 32'(bvalid), 32'd1);
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    chk("rd_rvalid", 32'(rvalid), 32'd1);
    data = rdata;
    resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic [31:0] held;

    aresetn = 1'b0; awaddr = '0; awprot = 3'b101; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b0; araddr = '0; arprot = 3'b010; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 4; i++) exp_regs[i] = '0;
    tick(); tick();
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready",  32'(wready),  32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_resp",    32'({bresp, rresp}), 32'd0);
    chk("rst_rdata",   rdata, 32'd0);
    aresetn = 1'b1;
    tick();

    // Basic full-word writes and read-back
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp);
      exp_regs[i] = 32'(i + 1);
      chk("basic_bresp", 32'(resp), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, resp);
      chk("basic_rdata", d, 32'(i + 1));
      chk("basic_rresp", 32'(resp), 32'd0);
    end

    // Byte strobes
    axi_write(5'h04, 32'hAABBCCDD, 4'hF, resp);
    axi_write(5'h04, 32'h11223344, 4'h5, resp);
    exp_regs[1] = 32'hAA22CC44;
    axi_read(5'h04, d, resp);
    chk("strb_rdata", d, 32'hAA22CC44);
    axi_write(5'h04, 32'hFFFFFFFF, 4'h0, resp);
    chk("strb0_bresp", 32'(resp), 32'd0);
    axi_read(5'h04, d, resp);
    chk("strb0_rdata", d, 32'hAA22CC44);

    // Unaligned read resolves to containing word
    axi_read(5'h0B, d, resp);
    chk("unaligned_rdata", d, exp_regs[2]);

    // W three cycles ahead of AW, BREADY held low
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    tick();
    wvalid = 1'b0;
    chk("wfirst_wready", 32'(wready), 32'd0);
    tick(); tick();
    awaddr = 5'h00; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("wfirst_bvalid_early", 32'(bvalid), 32'd0);
    tick();
    chk("wfirst_bvalid", 32'(bvalid), 32'd1);
    chk("wfirst_holds_free", 32'({awready, wready}), 32'd3);
    exp_regs[0] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wfirst_bvalid_hold", 32'({bvalid, bresp}), 32'h4);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("wfirst_bvalid_clr", 32'(bvalid), 32'd0);
    tick(); tick();
    chk("wfirst_no_second", 32'(bvalid), 32'd0);
    axi_read(5'h00, d, resp);
    chk("wfirst_rdata", d, 32'hDEADBEEF);

    // Read with RREADY stalled
    araddr = 5'h08; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    held = rdata;
    chk("stall_rdata", rdata, exp_regs[2]);
    for (int i = 0; i < 5; i++) begin
      chk("stall_arready", 32'(arready), 32'd0);
      chk("stall_rvalid",  32'(rvalid),  32'd1);
      chk("stall_rstable", rdata, exp_regs[2]);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("stall_release", 32'({rvalid, arready}), 32'd1);

    // AR handshake on the commit edge returns the old value
    awaddr = 5'h0C; wdata = 32'h00000055; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 5'h0C; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    chk("raw_rdata_old", rdata, exp_regs[3]);
    chk("raw_bvalid", 32'(bvalid), 32'd1);
    exp_regs[3] = 32'h00000055;
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_read(5'h0C, d, resp);
    chk("raw_rdata_new", d, 32'h00000055);

    // Out-of-range index
    axi_write(5'h14, 32'hFFFFFFFF, 4'hF, resp);
    chk("oor_bresp", 32'(resp), 32'(EXP_OOR));
    axi_read(5'h14, d, resp);
    chk("oor_rdata", d, 32'd0);
    chk("oor_rresp", 32'(resp), 32'(EXP_OOR));
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), d, resp);
      chk("oor_regs_intact", d, exp_regs[i]);
    end

    // Reset between AW and W handshakes
    awaddr = 5'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) exp_regs[i] = '0;
    chk("midrst_awready", 32'(awready), 32'd1);
    chk("midrst_bvalid",  32'(bvalid),  32'd0);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("midrst_w_accepted", 32'(wready), 32'd0);
    tick(); tick();
    chk("midrst_no_commit", 32'(bvalid), 32'd0);
    axi_read(5'h04, d, resp);
    chk("midrst_reg", d, 32'd0);
    axi_read(5'h00, d, resp);
    chk("midrst_reg0_cleared", d, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte-address width; register index = ADDR[4:2].
REQ-003 SHALL have parameter NUM_REGS, default 4, number of implemented 32-bit registers, located at offsets 0x0, 0x4, 0x8 and 0xC.
REQ-004 SHALL use one clock and a synchronous, active-low reset: ACLK in 1 (rising-edge clock), then ARESETN in 1 (synchronous active-low reset).
REQ-005 SHALL have the write-address ports S_AXI_AWADDR in C_S_AXI_ADDR_WIDTH, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1 and S_AXI_AWREADY out 1.
REQ-006 SHALL have the write-data ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1 and S_AXI_WREADY out 1.
REQ-007 SHALL have the write-response ports S_AXI_BRESP out 2, S_AXI_BVALID out 1 and S_AXI_BREADY in 1.
REQ-008 SHALL have the read-address ports S_AXI_ARADDR in C_S_AXI_ADDR_WIDTH, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1 and S_AXI_ARREADY out 1.
REQ-009 SHALL have the read-data ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1 and S_AXI_RREADY in 1.

Function
REQ-010 SHALL capture AW and W independently into holding registers (aw_held, w_held); AWREADY = !aw_held and WREADY = !w_held.
REQ-011 SHALL commit on the first edge where aw_held && w_held && !BVALID: write the addressed register, set BVALID=1, clear both holds.
REQ-012 SHALL write byte lane n of the register only when WSTRB[n]=1; with WSTRB=0 the register is unchanged and the response is still issued.
REQ-013 SHALL make the register update and BVALID visible one cycle after the later of the AW/W handshake edges (AW and W handshaked on edge k -> commit on edge k+1).
REQ-014 SHALL hold BVALID and BRESP stable until the edge where BVALID && BREADY, then clear BVALID; BVALID and BREADY both high on the same edge completes the response.
REQ-015 SHALL accept a new AW or W while BVALID is pending (holds are free) but SHALL NOT commit it until BVALID clears; maximum write throughput is one write per 2 cycles.
REQ-016 SHALL drive ARREADY = !RVALID; an AR handshake on edge k SHALL present RVALID=1, RDATA and RRESP after edge k.
REQ-017 SHALL hold RDATA, RRESP and RVALID stable while RVALID && !RREADY and clear RVALID on the RREADY handshake edge.
REQ-018 SHALL return the pre-write value when an AR handshake and a write commit to the same register occur on the same edge.
REQ-019 SHALL ignore ADDR[1:0] (unaligned addresses resolve to the containing word) and ignore AWPROT/ARPROT.
REQ-020 SHALL treat an index >= NUM_REGS as out-of-range: writes have no effect, reads return RDATA=0; RESP per REQ-025/026.
REQ-021 SHALL never drop VALID from a master-side perspective; outputs SHALL not depend combinationally on any VALID/READY input.

Reset
REQ-022 SHALL, on any edge with ARESETN=0, clear all registers to 0 and set AWREADY=1, WREADY=1, ARREADY=1, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, aw_held=0, w_held=0.
REQ-023 SHALL, on reset mid-transaction, discard the held AW/W and pending responses without committing any write.
REQ-024 SHALL, on the first edge after ARESETN rises, accept handshakes normally.

Configuration
REQ-025 SHALL, with AXIL_REG_SLVERR_EN defined, return BRESP/RRESP = 2'b10 (SLVERR) for out-of-range accesses and 2'b00 otherwise.
REQ-026 SHALL, without AXIL_REG_SLVERR_EN, return 2'b00 (OKAY) for all accesses, including out-of-range ones.

Verification
REQ-027 Bench SHALL write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC with WSTRB=0xF, then read all four -> RDATA 0x1..0x4, RRESP=OKAY.
REQ-028 Bench SHALL write 0xAABBCCDD to 0x4, then 0x11223344 with WSTRB=0x5 -> read 0xAA22CC44.
REQ-029 Bench SHALL present W 3 cycles before AW, with BREADY held low 4 cycles -> BVALID asserted one edge after the AW handshake and held stable 4 cycles; no second commit.
REQ-030 Bench SHALL read 0x8 with RREADY low 5 cycles -> ARREADY=0 throughout and RDATA stable.
REQ-031 Bench SHALL write to 0x14 and read 0x14 -> RDATA=0; RESP=2'b10 with AXIL_REG_SLVERR_EN, 2'b00 without; 0x0..0xC unchanged.
REQ-032 Bench SHALL assert ARESETN=0 for one cycle between the AW and W handshakes -> no register change and BVALID=0.
